// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end of the lab5 stepper sequencer: PC, ROM fetch sequencing, IR and one-hot decode.
// Optional ILLEGAL_TRAP_EN: opcodes C-F latch a sticky illegal_op and park the block in TRAP until reset.
module instr_fetch_decode #(
    parameter int unsigned PC_W        = 8,
    parameter int unsigned ROM_LATENCY = 1,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            increment_pc,
    input  logic            commit_branch,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] rom_addr,
    output logic            rom_rd,
    input  logic [7:0]      rom_q,
    output logic [PC_W-1:0] pc,
    output logic            instr_valid,
    output logic            br,
    output logic            brz,
    output logic            addi,
    output logic            subi,
    output logic            sr0,
    output logic            srh0,
    output logic            clr,
    output logic            mov,
    output logic            mova,
    output logic            movr,
    output logic            movrhs,
    output logic            pause,
    output logic [1:0]      rd,
    output logic [1:0]      rs,
    output logic [3:0]      imm4,
`ifdef ILLEGAL_TRAP_EN
    output logic            seq_error,
    output logic            illegal_op
`else
    output logic            seq_error
`endif
);

    localparam int unsigned CNT_W  = 2;
    localparam int unsigned IR_W   = 8;
    localparam int unsigned FLAG_W = 12;

`ifdef ILLEGAL_TRAP_EN
    typedef enum logic [1:0] {ST_ISSUE, ST_WAIT, ST_VALID, ST_TRAP} state_t;
`else
    typedef enum logic [1:0] {ST_ISSUE, ST_WAIT, ST_VALID} state_t;
`endif

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rom_rd_q, rom_rd_d;
    logic [FLAG_W-1:0] flags_c;
`ifdef ILLEGAL_TRAP_EN
    logic              illegal_q, illegal_d;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_ISSUE;
            pc_q     <= PC_W'(RESET_PC);
            ir_q     <= 8'h00;
            cnt_q    <= '0;
            rom_rd_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            cnt_q    <= cnt_d;
            rom_rd_q <= rom_rd_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // Next-state logic; the read strobe is registered so it is high exactly in the ISSUE cycle.
    // Straight out of reset the strobe is still low, so ISSUE holds one extra cycle to raise it.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
`ifdef ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            ST_ISSUE: begin
                if (rom_rd_q) begin
                    cnt_d   = CNT_W'(ROM_LATENCY - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    ir_d    = rom_q;
                    state_d = ST_VALID;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_VALID: begin
`ifdef ILLEGAL_TRAP_EN
                if (ir_q[7:6] == 2'b11) begin
                    illegal_d = 1'b1;
                    state_d   = ST_TRAP;
                end else
`endif
                if (commit_branch) begin
                    pc_d    = branch_target;
                    state_d = ST_ISSUE;
                end else if (increment_pc) begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_ISSUE;
                end
            end
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
`endif
            default: begin
                state_d = ST_ISSUE;
            end
        endcase
        rom_rd_d = (state_d == ST_ISSUE);
    end

    // One-hot opcode decode, forced low whenever the IR is not a valid instruction
    always_comb begin
        flags_c = '0;
        if (state_q == ST_VALID) begin
            case (ir_q[7:4])
                4'h0:    flags_c[0]  = 1'b1;
                4'h1:    flags_c[1]  = 1'b1;
                4'h2:    flags_c[2]  = 1'b1;
                4'h3:    flags_c[3]  = 1'b1;
                4'h4:    flags_c[4]  = 1'b1;
                4'h5:    flags_c[5]  = 1'b1;
                4'h6:    flags_c[6]  = 1'b1;
                4'h7:    flags_c[7]  = 1'b1;
                4'h8:    flags_c[8]  = 1'b1;
                4'h9:    flags_c[9]  = 1'b1;
                4'hA:    flags_c[10] = 1'b1;
                4'hB:    flags_c[11] = 1'b1;
                default: flags_c     = '0;
            endcase
        end
    end

    assign pause  = flags_c[0];
    assign br     = flags_c[1];
    assign brz    = flags_c[2];
    assign addi   = flags_c[3];
    assign subi   = flags_c[4];
    assign sr0    = flags_c[5];
    assign srh0   = flags_c[6];
    assign clr    = flags_c[7];
    assign mov    = flags_c[8];
    assign mova   = flags_c[9];
    assign movr   = flags_c[10];
    assign movrhs = flags_c[11];

    assign rom_addr    = pc_q;
    assign pc          = pc_q;
    assign rom_rd      = rom_rd_q;
    assign instr_valid = (state_q == ST_VALID);
    assign rd          = ir_q[3:2];
    assign rs          = ir_q[1:0];
    assign imm4        = ir_q[3:0];
`ifdef ILLEGAL_TRAP_EN
    assign illegal_op  = illegal_q;
`endif

    // A PC request that arrives while a fetch is in flight is dropped and flagged
    assign seq_error = reset_n & (increment_pc | commit_branch)
                     & ((state_q == ST_ISSUE) | (state_q == ST_WAIT));

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode: a latency-1 instance driven against a cycle model,
// plus a latency-3 instance (RESET_PC=0x10) for reset-during-fetch and, with ILLEGAL_TRAP_EN, the trap.
module tb_instr_fetch_decode;

    localparam int unsigned PC_W  = 8;
    localparam int unsigned LAT_A = 1;
    localparam int unsigned LAT_B = 3;
    localparam int unsigned RPC_B = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rom [256];

    // Instance A signals
    logic            rst_a_n, inc_a, cb_a, rom_rd_a, valid_a, seq_a;
    logic [PC_W-1:0] bt_a, rom_addr_a, pc_a;
    logic [7:0]      rq_a;
    logic [11:0]     fl_a;
    logic [1:0]      rd_a, rs_a;
    logic [3:0]      imm_a;
    // Instance B signals
    logic            rst_b_n, inc_b, cb_b, rom_rd_b, valid_b, seq_b;
    logic [PC_W-1:0] bt_b, rom_addr_b, pc_b;
    logic [7:0]      rq_b, sb0, sb1;
    logic [11:0]     fl_b;
    logic [1:0]      rd_b, rs_b;
    logic [3:0]      imm_b;
`ifdef ILLEGAL_TRAP_EN
    logic            illegal_a, illegal_b;
`endif

    instr_fetch_decode #(.PC_W(PC_W), .ROM_LATENCY(LAT_A), .RESET_PC(0)) u_dut_a (
        .clk(clk), .reset_n(rst_a_n), .increment_pc(inc_a), .commit_branch(cb_a),
        .branch_target(bt_a), .rom_addr(rom_addr_a), .rom_rd(rom_rd_a), .rom_q(rq_a),
        .pc(pc_a), .instr_valid(valid_a),
        .pause(fl_a[0]), .br(fl_a[1]), .brz(fl_a[2]), .addi(fl_a[3]), .subi(fl_a[4]),
        .sr0(fl_a[5]), .srh0(fl_a[6]), .clr(fl_a[7]), .mov(fl_a[8]), .mova(fl_a[9]),
        .movr(fl_a[10]), .movrhs(fl_a[11]),
        .rd(rd_a), .rs(rs_a), .imm4(imm_a),
`ifdef ILLEGAL_TRAP_EN
        .illegal_op(illegal_a),
`endif
        .seq_error(seq_a)
    );

    instr_fetch_decode #(.PC_W(PC_W), .ROM_LATENCY(LAT_B), .RESET_PC(RPC_B)) u_dut_b (
        .clk(clk), .reset_n(rst_b_n), .increment_pc(inc_b), .commit_branch(cb_b),
        .branch_target(bt_b), .rom_addr(rom_addr_b), .rom_rd(rom_rd_b), .rom_q(rq_b),
        .pc(pc_b), .instr_valid(valid_b),
        .pause(fl_b[0]), .br(fl_b[1]), .brz(fl_b[2]), .addi(fl_b[3]), .subi(fl_b[4]),
        .sr0(fl_b[5]), .srh0(fl_b[6]), .clr(fl_b[7]), .mov(fl_b[8]), .mova(fl_b[9]),
        .movr(fl_b[10]), .movrhs(fl_b[11]),
        .rd(rd_b), .rs(rs_b), .imm4(imm_b),
`ifdef ILLEGAL_TRAP_EN
        .illegal_op(illegal_b),
`endif
        .seq_error(seq_b)
    );

    // Synchronous ROMs: data is valid only in the cycle ROM_LATENCY after the strobe, garbage otherwise
    always @(posedge clk) rq_a <= rom_rd_a ? rom[rom_addr_a] : 8'($urandom);
    always @(posedge clk) begin
        sb0  <= rom_rd_b ? rom[rom_addr_b] : 8'($urandom);
        sb1  <= sb0;
        rq_b <= sb1;
    end

    // Model of instance A: PC, IR contents, and cycles remaining until the IR is valid
    logic [7:0] m_pc, m_ir;
    int         m_rem;

    function automatic logic [11:0] exp_flags(input logic [7:0] ir, input logic vld);
        if (vld && ir[7:4] < 4'd12) return 12'd1 << ir[7:4];
        return 12'd0;
    endfunction

    task automatic drive_a(input logic inc, input logic cb, input logic [7:0] bt);
        inc_a = inc; cb_a = cb; bt_a = bt;
        #1;
    endtask

    task automatic edge_a();
        @(posedge clk);
        if (m_rem == 0) begin
            if (cb_a) begin
                m_pc = bt_a; m_rem = LAT_A + 1;
            end else if (inc_a) begin
                m_pc = m_pc + 8'd1; m_rem = LAT_A + 1;
            end
        end else begin
            m_rem = m_rem - 1;
            if (m_rem == 0) m_ir = rom[m_pc];
        end
        @(negedge clk);
    endtask

    task automatic reset_a();
        @(negedge clk);
        rst_a_n = 1'b0; inc_a = 1'b0; cb_a = 1'b0; bt_a = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_a_n = 1'b1;
        m_pc = 8'h00; m_ir = 8'h00; m_rem = LAT_A + 2;
    endtask

    task automatic wait_valid_a();
        int n = 0;
        drive_a(1'b0, 1'b0, 8'h00);
        while (valid_a !== 1'b1 && n < 20) begin
            edge_a(); drive_a(1'b0, 1'b0, 8'h00); n++;
        end
        n_checks++;
        if (valid_a !== 1'b1) begin
            n_fail++; $display("FAIL wait_valid_a: instr_valid=%b after %0d cycles, required 1", valid_a, n);
        end
    endtask

    task automatic goto_a(input logic [7:0] addr);
        wait_valid_a();
        drive_a(1'b0, 1'b1, addr);
        edge_a();
        wait_valid_a();
    endtask

    task automatic test_reset();
        reset_a();
        drive_a(1'b0, 1'b0, 8'h00);
        n_checks++; if (rom_rd_a !== 1'b0) begin n_fail++; $display("FAIL reset_rom_rd: got %b required 0", rom_rd_a); end
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", valid_a); end
        n_checks++; if (pc_a !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h required 00", pc_a); end
        n_checks++; if (fl_a !== 12'h000) begin n_fail++; $display("FAIL reset_flags: got %h required 000", fl_a); end
        n_checks++; if (imm_a !== 4'h0) begin n_fail++; $display("FAIL reset_imm4: got %h required 0", imm_a); end
        n_checks++; if (seq_a !== 1'b0) begin n_fail++; $display("FAIL reset_seq_error: got %b required 0", seq_a); end
`ifdef ILLEGAL_TRAP_EN
        n_checks++; if (illegal_a !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b required 0", illegal_a); end
`endif
        edge_a(); drive_a(1'b0, 1'b0, 8'h00);
        n_checks++; if (rom_rd_a !== 1'b1 || rom_addr_a !== 8'h00) begin
            n_fail++; $display("FAIL first_issue: rom_rd=%b addr=%h required 1/00", rom_rd_a, rom_addr_a);
        end
        edge_a(); drive_a(1'b0, 1'b0, 8'h00);
        n_checks++; if (valid_a !== 1'b0 || rom_rd_a !== 1'b0) begin
            n_fail++; $display("FAIL first_wait: valid=%b rom_rd=%b required 0/0", valid_a, rom_rd_a);
        end
        edge_a(); drive_a(1'b0, 1'b0, 8'h00);
        n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b required 1", valid_a); end
        n_checks++; if (fl_a !== 12'h008) begin n_fail++; $display("FAIL first_addi: flags=%h required 008", fl_a); end
        n_checks++; if (rd_a !== 2'b11 || rs_a !== 2'b01 || imm_a !== 4'hD) begin
            n_fail++; $display("FAIL first_fields: rd=%b rs=%b imm4=%h required 11/01/d", rd_a, rs_a, imm_a);
        end
    endtask

    task automatic test_increment();
        goto_a(8'h05);
        drive_a(1'b1, 1'b0, 8'h00);
        n_checks++; if (pc_a !== 8'h05 || valid_a !== 1'b1) begin
            n_fail++; $display("FAIL inc_pre: pc=%h valid=%b required 05/1", pc_a, valid_a);
        end
        edge_a(); drive_a(1'b0, 1'b0, 8'h00);
        n_checks++; if (pc_a !== 8'h06 || fl_a !== 12'h000 || valid_a !== 1'b0) begin
            n_fail++; $display("FAIL inc_post: pc=%h flags=%h valid=%b required 06/000/0", pc_a, fl_a, valid_a);
        end
        n_checks++; if (rom_rd_a !== 1'b1 || rom_addr_a !== 8'h06) begin
            n_fail++; $display("FAIL inc_issue: rom_rd=%b addr=%h required 1/06", rom_rd_a, rom_addr_a);
        end
        for (int k = 1; k <= int'(LAT_A) + 1; k++) begin
            edge_a(); drive_a(1'b0, 1'b0, 8'h00);
            n_checks++; if (valid_a !== (k == int'(LAT_A) + 1)) begin
                n_fail++; $display("FAIL inc_latency: cycle %0d valid=%b required %b", k, valid_a, (k == int'(LAT_A) + 1));
            end
        end
        n_checks++; if (fl_a !== exp_flags(rom[6], 1'b1)) begin
            n_fail++; $display("FAIL inc_decode: flags=%h required %h", fl_a, exp_flags(rom[6], 1'b1));
        end
    endtask

    task automatic test_both_requests();
        goto_a(8'h07);
        drive_a(1'b1, 1'b1, 8'h20);
        edge_a(); drive_a(1'b0, 1'b0, 8'h00);
        n_checks++; if (pc_a !== 8'h20) begin n_fail++; $display("FAIL both_req_pc: got %h required 20", pc_a); end
        wait_valid_a();
        n_checks++; if (fl_a !== exp_flags(rom[8'h20], 1'b1) || imm_a !== rom[8'h20][3:0]) begin
            n_fail++; $display("FAIL both_req_decode: flags=%h imm4=%h required %h/%h", fl_a, imm_a,
                               exp_flags(rom[8'h20], 1'b1), rom[8'h20][3:0]);
        end
    endtask

    task automatic test_wrap();
        goto_a(8'hFF);
        drive_a(1'b1, 1'b0, 8'h00);
        edge_a(); drive_a(1'b0, 1'b0, 8'h00);
        n_checks++; if (pc_a !== 8'h00 || rom_rd_a !== 1'b1 || rom_addr_a !== 8'h00) begin
            n_fail++; $display("FAIL wrap: pc=%h rom_rd=%b addr=%h required 00/1/00", pc_a, rom_rd_a, rom_addr_a);
        end
        wait_valid_a();
        n_checks++; if (fl_a !== 12'h008) begin n_fail++; $display("FAIL wrap_decode: flags=%h required 008", fl_a); end
    endtask

    task automatic test_seq_error();
        goto_a(8'h40);
        drive_a(1'b1, 1'b0, 8'h00);
        edge_a(); drive_a(1'b0, 1'b1, 8'h99);
        n_checks++; if (seq_a !== 1'b1) begin n_fail++; $display("FAIL seq_err_issue: got %b required 1", seq_a); end
        edge_a(); drive_a(1'b1, 1'b0, 8'h00);
        n_checks++; if (seq_a !== 1'b1 || pc_a !== 8'h41) begin
            n_fail++; $display("FAIL seq_err_wait: seq_error=%b pc=%h required 1/41", seq_a, pc_a);
        end
        edge_a(); drive_a(1'b0, 1'b0, 8'h00);
        n_checks++; if (seq_a !== 1'b0 || pc_a !== 8'h41 || valid_a !== 1'b1) begin
            n_fail++; $display("FAIL seq_err_after: seq_error=%b pc=%h valid=%b required 0/41/1", seq_a, pc_a, valid_a);
        end
        n_checks++; if (fl_a !== exp_flags(rom[8'h41], 1'b1)) begin
            n_fail++; $display("FAIL seq_err_decode: flags=%h required %h", fl_a, exp_flags(rom[8'h41], 1'b1));
        end
    endtask

`ifndef ILLEGAL_TRAP_EN
    task automatic test_undefined_opcode();
        goto_a(8'h30);
        n_checks++; if (valid_a !== 1'b1 || fl_a !== 12'h000 || imm_a !== 4'h5) begin
            n_fail++; $display("FAIL undef_op: valid=%b flags=%h imm4=%h required 1/000/5", valid_a, fl_a, imm_a);
        end
        drive_a(1'b1, 1'b0, 8'h00);
        edge_a(); drive_a(1'b0, 1'b0, 8'h00);
        n_checks++; if (pc_a !== 8'h31) begin n_fail++; $display("FAIL undef_op_inc: pc=%h required 31", pc_a); end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic       inc, cb, vld;
            logic [7:0] bt;
            inc = ($urandom_range(0, 2) == 0);
            cb  = ($urandom_range(0, 4) == 0);
            bt  = 8'($urandom);
            drive_a(inc, cb, bt);
            vld = (m_rem == 0);
            n_checks++; if (pc_a !== m_pc || rom_addr_a !== m_pc) begin
                n_fail++; $display("FAIL rand_pc c=%0d: pc=%h addr=%h required %h", c, pc_a, rom_addr_a, m_pc);
            end
            n_checks++; if (valid_a !== vld) begin
                n_fail++; $display("FAIL rand_valid c=%0d: got %b required %b", c, valid_a, vld);
            end
            n_checks++; if (rom_rd_a !== (m_rem == int'(LAT_A) + 1)) begin
                n_fail++; $display("FAIL rand_rom_rd c=%0d: got %b required %b", c, rom_rd_a, (m_rem == int'(LAT_A) + 1));
            end
            n_checks++; if (fl_a !== exp_flags(m_ir, vld)) begin
                n_fail++; $display("FAIL rand_flags c=%0d: got %h required %h", c, fl_a, exp_flags(m_ir, vld));
            end
            n_checks++; if ({rd_a, rs_a} !== m_ir[3:0] || imm_a !== m_ir[3:0]) begin
                n_fail++; $display("FAIL rand_fields c=%0d: rd/rs=%h imm4=%h required %h", c, {rd_a, rs_a}, imm_a, m_ir[3:0]);
            end
            n_checks++; if (seq_a !== ((inc | cb) & !vld)) begin
                n_fail++; $display("FAIL rand_seq_error c=%0d: got %b required %b", c, seq_a, ((inc | cb) & !vld));
            end
            edge_a();
        end
    endtask

    // Instance B: ROM_LATENCY=3, RESET_PC=0x10
    task automatic reset_b();
        @(negedge clk);
        rst_b_n = 1'b0; inc_b = 1'b0; cb_b = 1'b0; bt_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b_n = 1'b1;
        #1;
    endtask

    task automatic test_reset_mid_fetch();
        reset_b();
        @(posedge clk); @(negedge clk); #1;
        n_checks++; if (rom_rd_b !== 1'b1 || rom_addr_b !== 8'h10) begin
            n_fail++; $display("FAIL lat3_issue: rom_rd=%b addr=%h required 1/10", rom_rd_b, rom_addr_b);
        end
        @(posedge clk); @(negedge clk);
        reset_b();
        n_checks++; if (valid_b !== 1'b0 || pc_b !== 8'h10 || rom_rd_b !== 1'b0) begin
            n_fail++; $display("FAIL lat3_reset: valid=%b pc=%h rom_rd=%b required 0/10/0", valid_b, pc_b, rom_rd_b);
        end
        for (int k = 1; k <= int'(LAT_B) + 2; k++) begin
            @(posedge clk); @(negedge clk); #1;
            n_checks++; if (valid_b !== (k == int'(LAT_B) + 2) || rom_rd_b !== (k == 1)) begin
                n_fail++; $display("FAIL lat3_timing: cycle %0d valid=%b rom_rd=%b required %b/%b", k, valid_b, rom_rd_b,
                                   (k == int'(LAT_B) + 2), (k == 1));
            end
        end
        n_checks++; if (fl_b !== 12'h400 || imm_b !== 4'h0 || pc_b !== 8'h10) begin
            n_fail++; $display("FAIL lat3_movr: flags=%h imm4=%h pc=%h required 400/0/10", fl_b, imm_b, pc_b);
        end
    endtask

`ifdef ILLEGAL_TRAP_EN
    task automatic test_trap();
        rom[RPC_B] = 8'hF0;
        reset_b();
        inc_b = 1'b1;
        repeat (12) begin @(posedge clk); @(negedge clk); end
        #1;
        n_checks++; if (illegal_b !== 1'b1 || valid_b !== 1'b0 || pc_b !== 8'h10 || fl_b !== 12'h000) begin
            n_fail++; $display("FAIL trap: illegal=%b valid=%b pc=%h flags=%h required 1/0/10/000", illegal_b, valid_b, pc_b, fl_b);
        end
        cb_b = 1'b1; bt_b = 8'h55;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        #1;
        n_checks++; if (illegal_b !== 1'b1 || pc_b !== 8'h10 || rom_rd_b !== 1'b0) begin
            n_fail++; $display("FAIL trap_hold: illegal=%b pc=%h rom_rd=%b required 1/10/0", illegal_b, pc_b, rom_rd_b);
        end
        inc_b = 1'b0; cb_b = 1'b0;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a_n = 1'b0; inc_a = 1'b0; cb_a = 1'b0; bt_a = '0;
        rst_b_n = 1'b0; inc_b = 1'b0; cb_b = 1'b0; bt_b = '0;
        for (int i = 0; i < 256; i++) begin
            rom[i] = 8'($urandom);
`ifdef ILLEGAL_TRAP_EN
            rom[i][7:4] = 4'($urandom_range(0, 11));
`endif
        end
        rom[8'h00] = 8'h3D;
        rom[RPC_B] = 8'hA0;
`ifndef ILLEGAL_TRAP_EN
        rom[8'h30] = 8'hC5;
`endif
        test_reset();
        test_increment();
        test_both_requests();
        test_wrap();
        test_seq_error();
`ifndef ILLEGAL_TRAP_EN
        test_undefined_opcode();
`endif
        test_random();
        test_reset_mid_fetch();
`ifdef ILLEGAL_TRAP_EN
        test_trap();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
Front end of the lab5 stepper-motor sequencer. Holds the program counter and fetches 8-bit instructions from synchronous program ROM into an instruction register. Decodes the instruction into the one-hot opcode flags and operand fields that the control FSM consumes. Applies the FSM's PC-advance and branch-commit requests and refetches after every PC change.

Parameters:
PC_W, 8, program counter / ROM address width
ROM_LATENCY, 1, ROM cycles from rom_rd to valid rom_q (1..3)
RESET_PC, 0, PC value after reset

Ports:
clk  input  1  clock
reset_n  input  1  synchronous active-low reset
increment_pc  input  1  FSM request: pc <= pc+1
commit_branch  input  1  FSM request: pc <= branch_target
branch_target  input  PC_W  branch address from datapath ALU
rom_addr  output  PC_W  ROM address (= pc)
rom_rd  output  1  ROM read strobe
rom_q  input  8  ROM read data
pc  output  PC_W  current program counter
instr_valid  output  1  IR holds the instruction at pc
br, brz, addi, subi, sr0, srh0, clr, mov, mova, movr, movrhs, pause  output  1 each  one-hot decode flags
rd  output  2  IR[3:2]
rs  output  2  IR[1:0]
imm4  output  4  IR[3:0]
seq_error  output  1  one-cycle pulse: PC request while not valid

Behaviour:
- Interface: reset reset_n, synchronous, active-low; clock clk.
- Reset: pc=RESET_PC, IR=8'h00, state ISSUE, instr_valid=0, all flags 0, rom_rd=0, seq_error=0. Reset mid-fetch abandons the fetch; late rom_q is ignored.
- States: ISSUE, WAIT, VALID.
- ISSUE: rom_rd=1 for one cycle, rom_addr=pc. Load wait counter with ROM_LATENCY-1. Go to WAIT.
- WAIT: count down. When the count reaches 0, IR <= rom_q and go to VALID.
- Fetch latency: a PC update at edge E gives instr_valid=1 in the cycle starting at edge E+ROM_LATENCY+1.
- VALID: instr_valid=1. Flags are decoded from IR[7:4]: 0 pause, 1 br, 2 brz, 3 addi, 4 subi, 5 sr0, 6 srh0, 7 clr, 8 mov, 9 mova, A movr, B movrhs, C-F none.
- Flag gating: flags are combinational from IR, ANDed with instr_valid. Outside VALID all flags are 0. At most one flag is high at any time.
- rd/rs/imm4 are always driven from IR, valid or not.
- In VALID, commit_branch: pc <= branch_target, go to ISSUE.
- In VALID, increment_pc without commit_branch: pc <= pc+1 modulo 2^PC_W (all-ones wraps to 0), go to ISSUE.
- Both requests asserted together: commit_branch wins, no increment.
- Neither request: stay in VALID with IR held. Multi-cycle FSM states (MOVR/PAUSE delays) rely on this.
- increment_pc or commit_branch in ISSUE/WAIT: request ignored, pc unchanged, seq_error pulses high for that cycle.
- rom_rd is high only in ISSUE. rom_addr=pc at all times.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: opcodes C-F in VALID set a sticky output illegal_op (1 bit, reset 0) and move to state TRAP. TRAP holds pc and IR, keeps instr_valid=0, and ignores all requests until reset.
- Undefined: no illegal_op port and no TRAP state. An undefined opcode stays in VALID with all flags 0.

Test Plan:
- Reset with ROM[0]=8'h3D, ROM_LATENCY=1 -> rom_rd in cycle 1 with addr 0; instr_valid from cycle 3; addi=1, rd=2'b11, rs=2'b01, others 0.
- In VALID at pc=5, pulse increment_pc -> pc=6; flags drop next cycle; rom_rd with addr 6; valid returns ROM_LATENCY+1 cycles after the pc update.
- increment_pc and commit_branch together with branch_target=8'h20 at pc=7 -> pc=8'h20, not 8.
- pc=8'hFF, increment_pc -> pc=8'h00; fetch from address 0.
- increment_pc asserted during WAIT -> pc unchanged, seq_error=1 for exactly that cycle; fetch completes normally.
- ROM_LATENCY=3, reset_n low during WAIT, then ROM[RESET_PC]=8'hA0 -> fresh fetch from RESET_PC; movr=1; with ILLEGAL_TRAP_EN and ROM=8'hF0, illegal_op=1 and pc frozen.
